// File: rtl/regfile_dump_tx_if.sv
// Byte-stream handshake between the regfile dump engine and the board UART
// transmitter. A byte moves on a rising clock edge where tx_valid & tx_ready.
interface regfile_dump_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/regfile_dump_tx.sv
// Register-file dump engine: a synchronised, edge-detected BTND press takes
// over the regfile rs1 read port, reads r0..r(NUM_REGS-1) in order and streams
// them as a framed, little-endian byte stream (HDR, register bytes, TRL).
module regfile_dump_tx #(
    parameter int          NUM_REGS    = 32,
    parameter int          REG_WIDTH   = 32,
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  HDR_BYTE    = 8'hA5,
    parameter logic [7:0]  TRL_BYTE    = 8'h5A
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  BTND,
    input  logic [4:0]            rs1_core,
    output logic [4:0]            rs1,
    input  logic [REG_WIDTH-1:0]  regA,
    regfile_dump_tx_if.master     tx,
    output logic                  busy,
    output logic                  done
);

    localparam int BYTES = REG_WIDTH / 8;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(BYTES - 1);
    localparam logic [4:0]      IDX_LAST = 5'(NUM_REGS - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_SEL  = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
    localparam logic [2:0] S_TRL  = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   start;
    logic [2:0]             state;
    logic [4:0]             index;
    logic [REG_WIDTH-1:0]   sr;
    logic [BC_W-1:0]        bc;
    logic                   xfer;

    // Synchronise the raw button and keep the previous synchronised level for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], BTND};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign start = sync_q[SYNC_STAGES-1] & ~edge_q;

    // Decode busy, read-port mux and the byte presented to the transmitter from the state
    always_comb begin
        busy        = (state != S_IDLE);
        rs1         = busy ? index : rs1_core;
        tx.tx_valid = 1'b0;
        tx.tx_data  = 8'h00;
        case (state)
            S_HDR: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = HDR_BYTE;
            end
            S_SEND: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = sr[7:0];
            end
            S_TRL: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = TRL_BYTE;
            end
            default: begin
                tx.tx_valid = 1'b0;
                tx.tx_data  = 8'h00;
            end
        endcase
        xfer = tx.tx_valid & tx.tx_ready;
    end

    // Frame sequencer: header, per-register capture then LSB-first bytes, trailer, done pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            index <= '0;
            sr    <= '0;
            bc    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (xfer) begin
                        state <= S_SEL;
                    end
                end
                S_SEL: begin
                    sr    <= regA;
                    bc    <= '0;
                    state <= S_SEND;
                end
                S_SEND: begin
                    if (xfer) begin
                        sr <= sr >> 8;
                        bc <= bc + 1'b1;
                        if (bc == BC_LAST) begin
                            if (index == IDX_LAST) begin
                                state <= S_TRL;
                            end else begin
                                index <= index + 5'd1;
                                state <= S_SEL;
                            end
                        end
                    end
                end
                S_TRL: begin
                    if (xfer) begin
                        state <= S_IDLE;
                        index <= '0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Self-checking bench for regfile_dump_tx: reset/passthrough vector table,
// then full frames against a byte-level frame model built from a regfile snapshot.
module tb_regfile_dump_tx;

    localparam int         NUM_REGS  = 32;
    localparam int         REG_WIDTH = 32;
    localparam int         FRAME_LEN = 2 + NUM_REGS * REG_WIDTH / 8;
    localparam logic [7:0] HDR       = 8'hA5;
    localparam logic [7:0] TRL       = 8'h5A;

    logic        clock    = 1'b0;
    logic        reset    = 1'b0;
    logic        BTND     = 1'b0;
    logic [4:0]  rs1_core = 5'd0;
    logic [4:0]  rs1;
    logic [31:0] regA;
    logic        busy;
    logic        done;

    logic [31:0] regs [NUM_REGS];

    regfile_dump_tx_if txif();

    assign regA = regs[rs1];

    regfile_dump_tx #(
        .NUM_REGS   (NUM_REGS),
        .REG_WIDTH  (REG_WIDTH),
        .SYNC_STAGES(2),
        .HDR_BYTE   (HDR),
        .TRL_BYTE   (TRL)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .BTND    (BTND),
        .rs1_core(rs1_core),
        .rs1     (rs1),
        .regA    (regA),
        .tx      (txif),
        .busy    (busy),
        .done    (done)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: received bytes, busy/done counts and stall-hold violations (sampled at negedge)
    logic [7:0] rx_q [$];
    int         busy_cycles  = 0;
    int         done_pulses  = 0;
    int         stall_viol   = 0;
    int         stall_checks = 0;
    logic       prev_stall   = 1'b0;
    logic [7:0] prev_data    = 8'h00;

    always @(negedge clock) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                stall_checks++;
                if (!(txif.tx_valid === 1'b1 && txif.tx_data === prev_data)) stall_viol++;
            end
            if (txif.tx_valid === 1'b1 && txif.tx_ready === 1'b1) rx_q.push_back(txif.tx_data);
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1) done_pulses++;
            prev_stall = txif.tx_valid && !txif.tx_ready;
            prev_data  = txif.tx_data;
        end
    end

    // Reference frame: header, each register LSB byte first, trailer
    logic [7:0] exp_q [$];

    task automatic build_exp(input logic [31:0] snap [NUM_REGS]);
        exp_q.delete();
        exp_q.push_back(HDR);
        for (int k = 0; k < NUM_REGS; k++)
            for (int b = 0; b < REG_WIDTH / 8; b++)
                exp_q.push_back(8'((snap[k] >> (8 * b)) & 32'hFF));
        exp_q.push_back(TRL);
    endtask

    task automatic compare_frame(input string tag, input int base);
        check({tag, "_len"}, 64'(rx_q.size() - base), 64'(FRAME_LEN));
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < rx_q.size())
                check($sformatf("%s_byte%0d", tag, i), rx_q[base + i], exp_q[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            BTND = 1'b0;
            txif.tx_ready = 1'b1;
        end
    endtask

    // mode 0: plain press, 1: bounce during frame, 2: regfile writes around r5 capture, 3: reset at byte 40
    task automatic run_frame(input int pct, input int mode, input int base, output bit ended);
        int c;
        c = 0;
        ended = 1'b0;
        @(posedge clock);
        #1;
        BTND = 1'b1;
        txif.tx_ready = ($urandom_range(0, 99) < pct);
        while (!ended && c < 3000) begin
            @(posedge clock);
            c++;
            #1;
            BTND = (c < 4) || (mode == 1 && c >= 20 && c < 40 && (c % 2 == 1));
            txif.tx_ready = ($urandom_range(0, 99) < pct);
            if (mode == 2 && busy && rs1 == 5'd3) regs[5] = 32'hDEADBEEF;
            if (mode == 2 && busy && rs1 == 5'd6) regs[5] = 32'h0;
            if (mode == 3 && (rx_q.size() - base) >= 40) begin
                reset = 1'b0;
                #1;
                check("abort_tx_valid", txif.tx_valid, 1'b0);
                check("abort_busy", busy, 1'b0);
                check("abort_tx_data", txif.tx_data, 8'h00);
                ended = 1'b1;
            end else begin
                @(negedge clock);
                if (c <= 3) check($sformatf("start_busy_edge%0d", c), busy, (c == 3));
                if (c == 3) begin
                    check("start_hdr_valid", txif.tx_valid, 1'b1);
                    check("start_hdr_data", txif.tx_data, HDR);
                end
                if (done === 1'b1) ended = 1'b1;
            end
        end
        check($sformatf("frame_end_seen_mode%0d", mode), ended, 1'b1);
    endtask

    typedef struct {
        logic       rst_n;
        logic       btnd;
        logic       rdy;
        logic [4:0] core;
        logic [4:0] e_rs1;
        logic       e_busy;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_done;
    } vec_t;

    initial begin
        vec_t        vt [8];
        logic [31:0] snap [NUM_REGS];
        int          base;
        int          b_busy;
        int          b_done;
        int          b_viol;
        int          b_sc;
        bit          ended;

        txif.tx_ready = 1'b1;
        for (int k = 0; k < NUM_REGS; k++) regs[k] = 32'(k) * 32'h01010101 + 32'd1;

        // reset held (button toggling) then idle after release: outputs zero, rs1 passthrough
        vt[0] = '{1'b0, 1'b1, 1'b1, 5'd7,  5'd7,  1'b0, 1'b0, 8'h00, 1'b0};
        vt[1] = '{1'b0, 1'b0, 1'b1, 5'd3,  5'd3,  1'b0, 1'b0, 8'h00, 1'b0};
        vt[2] = '{1'b0, 1'b1, 1'b1, 5'd31, 5'd31, 1'b0, 1'b0, 8'h00, 1'b0};
        vt[3] = '{1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 8'h00, 1'b0};
        vt[4] = '{1'b0, 1'b1, 1'b1, 5'd18, 5'd18, 1'b0, 1'b0, 8'h00, 1'b0};
        vt[5] = '{1'b1, 1'b0, 1'b1, 5'd7,  5'd7,  1'b0, 1'b0, 8'h00, 1'b0};
        vt[6] = '{1'b1, 1'b0, 1'b0, 5'd12, 5'd12, 1'b0, 1'b0, 8'h00, 1'b0};
        vt[7] = '{1'b1, 1'b0, 1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 8'h00, 1'b0};

        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            reset         = vt[i].rst_n;
            BTND          = vt[i].btnd;
            txif.tx_ready = vt[i].rdy;
            rs1_core      = vt[i].core;
            @(negedge clock);
            check($sformatf("vec%0d_rs1", i), rs1, vt[i].e_rs1);
            check($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
            check($sformatf("vec%0d_valid", i), txif.tx_valid, vt[i].e_valid);
            check($sformatf("vec%0d_data", i), txif.tx_data, vt[i].e_data);
            check($sformatf("vec%0d_done", i), done, vt[i].e_done);
        end
        idle(5);

        // Frame A: rk = k*0x01010101+1, tx_ready tied high
        snap = regs;
        build_exp(snap);
        base = rx_q.size(); b_busy = busy_cycles; b_done = done_pulses; b_viol = stall_viol;
        run_frame(100, 0, base, ended);
        idle(30);
        compare_frame("fullA", base);
        check("fullA_busy_cycles", 64'(busy_cycles - b_busy), 64'(2 + NUM_REGS * (1 + REG_WIDTH / 8)));
        check("fullA_done_pulses", 64'(done_pulses - b_done), 64'd1);
        check("fullA_stall_viol", 64'(stall_viol - b_viol), 64'd0);

        // Frame B: random contents, ~30% tx_ready duty
        for (int k = 0; k < NUM_REGS; k++) regs[k] = $urandom;
        snap = regs;
        build_exp(snap);
        base = rx_q.size(); b_done = done_pulses; b_viol = stall_viol; b_sc = stall_checks;
        run_frame(30, 0, base, ended);
        idle(30);
        compare_frame("bp", base);
        check("bp_done_pulses", 64'(done_pulses - b_done), 64'd1);
        check("bp_stall_viol", 64'(stall_viol - b_viol), 64'd0);
        check("bp_stalls_exercised", 64'(stall_checks - b_sc > 0), 64'd1);

        // Frame C: r5 written DEADBEEF before its capture, cleared after it
        for (int k = 0; k < NUM_REGS; k++) regs[k] = 32'(k) * 32'h01010101 + 32'd1;
        regs[5] = 32'h11111111;
        snap = regs;
        snap[5] = 32'hDEADBEEF;
        build_exp(snap);
        base = rx_q.size();
        run_frame(100, 2, base, ended);
        idle(30);
        compare_frame("capture", base);

        // Frame D: 10 bounce edges while busy yield a single frame
        for (int k = 0; k < NUM_REGS; k++) regs[k] = $urandom;
        snap = regs;
        build_exp(snap);
        base = rx_q.size(); b_done = done_pulses;
        run_frame(100, 1, base, ended);
        idle(200);
        compare_frame("bounce", base);
        check("bounce_done_pulses", 64'(done_pulses - b_done), 64'd1);
        check("bounce_idle_after", busy, 1'b0);

        // Frame E: reset asserted after 40 bytes
        base = rx_q.size();
        run_frame(70, 3, base, ended);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("abort_hold_busy", busy, 1'b0);
        check("abort_hold_valid", txif.tx_valid, 1'b0);
        check("abort_hold_done", done, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle(5);

        // Frame F: fresh frame after the abandoned one
        for (int k = 0; k < NUM_REGS; k++) regs[k] = $urandom;
        snap = regs;
        build_exp(snap);
        base = rx_q.size(); b_busy = busy_cycles; b_done = done_pulses;
        run_frame(100, 0, base, ended);
        idle(30);
        compare_frame("after_abort", base);
        check("after_abort_busy_cycles", 64'(busy_cycles - b_busy), 64'(2 + NUM_REGS * (1 + REG_WIDTH / 8)));
        check("after_abort_done_pulses", 64'(done_pulses - b_done), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
